// File: rtl/bitwise_logic_pkg.sv
// Shared op codes and skid-buffer state encoding
// for the bitwise logic unit.
package bitwise_logic_pkg;

    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_PASS = 3'b100;
    localparam logic [2:0] OP_SWAP = 3'b101;
    localparam logic [2:0] OP_SHL1 = 3'b110;
    localparam logic [2:0] OP_ROR1 = 3'b111;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/bitwise_logic_core.sv
// Combinational datapath: (a, b, op) -> (x, y).
// Shared by both result channels of the unit.
module bitwise_logic_core
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o
);

    // Decode op; y is the complement of x for the two-operand ops.
    always_comb begin
        x_o = '0;
        y_o = '0;
        unique case (op_i)
            OP_NOT: begin
                x_o = ~a_i;
                y_o = ~b_i;
            end
            OP_AND: begin
                x_o = a_i & b_i;
                y_o = ~(a_i & b_i);
            end
            OP_OR: begin
                x_o = a_i | b_i;
                y_o = ~(a_i | b_i);
            end
            OP_XOR: begin
                x_o = a_i ^ b_i;
                y_o = ~(a_i ^ b_i);
            end
            OP_PASS: begin
                x_o = a_i;
                y_o = b_i;
            end
            OP_SWAP: begin
                x_o = b_i;
                y_o = a_i;
            end
            OP_SHL1: begin
                x_o = {a_i[WIDTH-2:0], 1'b0};
                y_o = {b_i[WIDTH-2:0], 1'b0};
            end
            OP_ROR1: begin
                x_o = {a_i[0], a_i[WIDTH-1:1]};
                y_o = {b_i[0], b_i[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit with a 2-entry skid buffer.
// Optional macro LOGIC_ZFLAG_EN adds x_zero/y_zero outputs.
module bitwise_logic_unit
    import bitwise_logic_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] op_count
`ifdef LOGIC_ZFLAG_EN
    ,
    output logic             x_zero,
    output logic             y_zero
`endif
);

`ifdef LOGIC_ZFLAG_EN
    localparam int EW = 2*WIDTH + 2;
`else
    localparam int EW = 2*WIDTH;
`endif

    logic [WIDTH-1:0] core_x;
    logic [WIDTH-1:0] core_y;
    logic [EW-1:0]    new_e;

    buf_state_e       state_q, state_d;
    logic [EW-1:0]    head_q, head_d;
    logic [EW-1:0]    skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             push, pop;

    bitwise_logic_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i  (a),
        .b_i  (b),
        .op_i (op),
        .x_o  (core_x),
        .y_o  (core_y)
    );

`ifdef LOGIC_ZFLAG_EN
    assign new_e  = {core_x == '0, core_y == '0, core_x, core_y};
    assign x_zero = head_q[EW-1];
    assign y_zero = head_q[EW-2];
`else
    assign new_e  = {core_x, core_y};
`endif

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign x         = head_q[2*WIDTH-1:WIDTH];
    assign y         = head_q[WIDTH-1:0];
    assign op_count  = cnt_q;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid & out_ready;

    // Buffer FSM: decide occupancy, which entry loads, and counter step.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        cnt_d   = pop ? cnt_q + CNT_W'(1) : cnt_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_d  = new_e;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d = TWO;
                    skid_d  = new_e;
                end else if (pop && !push) begin
                    state_d = EMPTY;
                end else if (push && pop) begin
                    head_d  = new_e;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d = (state_d != TWO);
    end

    // State, entries and counter; reset drops both entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit (CNT_W=16 and CNT_W=4
// instances on shared stimulus), scoreboard-based result checking.
module tb_bitwise_logic_unit;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a, b;
    logic [2:0] op;
    logic       out_ready;

    logic        in_ready, out_valid;
    logic [3:0]  x, y;
    logic [15:0] op_count;

    logic        in_ready4, out_valid4;
    logic [3:0]  x4, y4;
    logic [3:0]  op_count4;

`ifdef LOGIC_ZFLAG_EN
    logic x_zero, y_zero, x_zero4, y_zero4;
`endif

    int passed = 0;
    int total  = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    bitwise_logic_unit #(.WIDTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .y         (y),
        .op_count  (op_count)
`ifdef LOGIC_ZFLAG_EN
        ,
        .x_zero    (x_zero),
        .y_zero    (y_zero)
`endif
    );

    bitwise_logic_unit #(.WIDTH(4), .CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .x         (x4),
        .y         (y4),
        .op_count  (op_count4)
`ifdef LOGIC_ZFLAG_EN
        ,
        .x_zero    (x_zero4),
        .y_zero    (y_zero4)
`endif
    );

    function automatic res_t model(input logic [3:0] ma, input logic [3:0] mb,
                                   input logic [2:0] mop);
        res_t r;
        case (mop)
            3'd0: begin r.x = ~ma;      r.y = ~mb; end
            3'd1: begin r.x = ma & mb;  r.y = ~(ma & mb); end
            3'd2: begin r.x = ma | mb;  r.y = ~(ma | mb); end
            3'd3: begin r.x = ma ^ mb;  r.y = ~(ma ^ mb); end
            3'd4: begin r.x = ma;       r.y = mb; end
            3'd5: begin r.x = mb;       r.y = ma; end
            3'd6: begin r.x = {ma[2:0], 1'b0}; r.y = {mb[2:0], 1'b0}; end
            default: begin r.x = {ma[0], ma[3:1]}; r.y = {mb[0], mb[3:1]}; end
        endcase
        return r;
    endfunction

    // Scoreboard: push on accept, pop/compare on delivery.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                res_t e;
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_extra: got x=%b y=%b, required no output", x, y);
                end else begin
                    e = sb.pop_front();
                    if (x !== e.x || y !== e.y || x4 !== e.x || y4 !== e.y)
                        $display("FAIL sb_result: got x=%b y=%b (x4=%b y4=%b), required x=%b y=%b",
                                 x, y, x4, y4, e.x, e.y);
                    else
                        passed++;
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(a, b, op));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0 || out_valid4 !== 1'b0)
            $display("FAIL reset_out_valid: got %b/%b, required 0", out_valid, out_valid4);
        else passed++;
        total++;
        if (x !== 4'b0 || y !== 4'b0)
            $display("FAIL reset_xy: got x=%b y=%b, required 0000/0000", x, y);
        else passed++;
        total++;
        if (op_count !== 16'd0 || op_count4 !== 4'd0)
            $display("FAIL reset_count: got %0d/%0d, required 0", op_count, op_count4);
        else passed++;
        total++;
        if (in_ready !== 1'b0)
            $display("FAIL reset_in_ready: got %b, required 0", in_ready);
        else passed++;
        rst = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1 || in_ready4 !== 1'b1)
            $display("FAIL reset_release_ready: got %b/%b, required 1", in_ready, in_ready4);
        else passed++;
    endtask

    task automatic test_all_ops();
        logic [3:0] ex [8] = '{4'b0101, 4'b0000, 4'b1111, 4'b1111,
                               4'b1010, 4'b0101, 4'b0100, 4'b0101};
        logic [3:0] ey [8] = '{4'b1010, 4'b1111, 4'b0000, 4'b0000,
                               4'b0101, 4'b1010, 4'b1010, 4'b1010};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            a = 4'b1010;
            b = 4'b0101;
            op = 3'(i);
            tick();
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b1 || x !== ex[i] || y !== ey[i])
                $display("FAIL op_%0d: got v=%b x=%b y=%b, required v=1 x=%b y=%b",
                         i, out_valid, x, y, ex[i], ey[i]);
            else passed++;
            tick();
        end
        total++;
        if (op_count !== 16'd8)
            $display("FAIL ops_count: got %0d, required 8", op_count);
        else passed++;
    endtask

    task automatic test_back_pressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 4'b0001; b = 4'b1000; op = 3'b000;
        tick();
        a = 4'b1100; b = 4'b0011; op = 3'b011;
        tick();
        a = 4'b1111; b = 4'b0000; op = 3'b101;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || x !== 4'b1110 || y !== 4'b0111)
            $display("FAIL bp_full: got rdy=%b v=%b x=%b y=%b, required 0 1 1110 0111",
                     in_ready, out_valid, x, y);
        else passed++;
        tick();
        tick();
        total++;
        if (in_ready !== 1'b0 || x !== 4'b1110 || y !== 4'b0111)
            $display("FAIL bp_hold: got rdy=%b x=%b y=%b, required 0 1110 0111",
                     in_ready, x, y);
        else passed++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || x !== 4'b1111 || y !== 4'b0000 || in_ready !== 1'b1)
            $display("FAIL bp_second: got v=%b x=%b y=%b rdy=%b, required 1 1111 0000 1",
                     out_valid, x, y, in_ready);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0 || op_count !== 16'd2)
            $display("FAIL bp_drain: got v=%b cnt=%0d, required v=0 cnt=2", out_valid, op_count);
        else passed++;
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            a = 4'($urandom);
            b = 4'($urandom);
            op = 3'($urandom);
            total++;
            if (in_ready !== 1'b1)
                $display("FAIL stream_ready_%0d: got %b, required 1", i, in_ready);
            else passed++;
            tick();
            total++;
            if (out_valid !== 1'b1)
                $display("FAIL stream_valid_%0d: got %b, required 1", i, out_valid);
            else passed++;
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (op_count !== 16'd20 || op_count4 !== 4'd4 || out_valid !== 1'b0)
            $display("FAIL stream_count: got %0d/%0d v=%b, required 20/4 v=0",
                     op_count, op_count4, out_valid);
        else passed++;
    endtask

    task automatic test_wrap_reset();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            a = 4'($urandom);
            b = 4'($urandom);
            op = 3'($urandom);
            tick();
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (op_count4 !== 4'd1 || op_count !== 16'd17)
            $display("FAIL wrap_count: got %0d/%0d, required 1/17", op_count4, op_count);
        else passed++;
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 4'b0110; b = 4'b1001; op = 3'b001;
        tick();
        a = 4'b0011; b = 4'b0101; op = 3'b010;
        tick();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL wrap_full: got rdy=%b v=%b, required 0 1", in_ready, out_valid);
        else passed++;
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_valid4 !== 1'b0 || op_count !== 16'd0 ||
            op_count4 !== 4'd0 || x !== 4'b0 || y !== 4'b0)
            $display("FAIL midop_reset: got v=%b/%b cnt=%0d/%0d x=%b y=%b, required 0 0 0 0 0000 0000",
                     out_valid, out_valid4, op_count, op_count4, x, y);
        else passed++;
        rst = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1 || in_ready4 !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL midop_release: got rdy=%b/%b v=%b, required 1 1 0",
                     in_ready, in_ready4, out_valid);
        else passed++;
    endtask

    task automatic test_zflag();
`ifdef LOGIC_ZFLAG_EN
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 4'b1100; b = 4'b0011; op = 3'b001;
        tick();
        a = 4'b0001; b = 4'b0000; op = 3'b100;
        tick();
        in_valid = 1'b0;
        total++;
        if (x_zero !== 1'b1 || y_zero !== 1'b0 || x_zero4 !== 1'b1)
            $display("FAIL zflag_and: got xz=%b yz=%b, required 1 0", x_zero, y_zero);
        else passed++;
        tick();
        tick();
        total++;
        if (x_zero !== 1'b1 || y_zero !== 1'b0 || x !== 4'b0000)
            $display("FAIL zflag_hold: got xz=%b yz=%b x=%b, required 1 0 0000",
                     x_zero, y_zero, x);
        else passed++;
        out_ready = 1'b1;
        tick();
        total++;
        if (x_zero !== 1'b0 || y_zero !== 1'b1)
            $display("FAIL zflag_skid: got xz=%b yz=%b, required 0 1", x_zero, y_zero);
        else passed++;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_all_ops();
        test_back_pressure();
        test_streaming();
        test_wrap_reset();
        test_zflag();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
